outport_uart_tx: RTL
====================

// Module: outport_uart_tx
// PURPOSE
//  Serial transmitter on the far side of the MiniSRC output port. The CPU's
//  out instruction pulses OutPort_in with the bus value. This block buffers
//  the low byte of each write in a small FIFO and sends it as 8N1 UART frames
//  on a single tx line. It sits beside the datapath on the Outport_Data_Out
//  path and feeds a host terminal or a bench receiver model.
// PARAMETERS
//  CLKS_PER_BIT  16  clk cycles per serial bit; must be >=2
//  FIFO_DEPTH    4   byte entries; power of two, >=2
// PORTS
//  clk        in   1   system clock; all logic acts on the rising edge
//  reset      in   1   synchronous reset, active-high
//  wr_en      in   1   one-cycle write strobe (OutPort_in)
//  wr_data    in   32  out-port data; only [7:0] is transmitted
//  tx         out  1   serial line; idles high
//  busy       out  1   high while a frame is in progress (state != IDLE)
//  full       out  1   FIFO holds FIFO_DEPTH bytes
//  empty      out  1   FIFO holds 0 bytes
//  overflow   out  1   sticky: a write was dropped; cleared only by reset
// BEHAVIOUR
//  - Clock and reset: one clock; reset is synchronous and active-high.
//  - Reset values: tx=1, busy=0, full=0, empty=1, overflow=0. Reset also
//    clears the FIFO pointers and count, the baud counter and the bit index.
//  - Outputs: all outputs are registered or decoded from registers only.
//  - Write acceptance: wr_en with full=0 stores wr_data[7:0] at the tail.
//    wr_en with full=1 drops the byte and sets overflow. full is sampled
//    before any same-cycle pop, so a write to a full FIFO is dropped even
//    when a pop happens in that cycle.
//  - Simultaneous write and pop (FIFO not full): count is unchanged and the
//    pointers advance. Pointers wrap modulo FIFO_DEPTH.
//  - FSM states: IDLE, START, DATA, STOP. A baud counter runs 0..CLKS_PER_BIT-1.
//    Every bit is held for exactly CLKS_PER_BIT cycles.
//  - IDLE: tx=1. If empty=0, at the next edge the FSM pops the head into the
//    shift register, goes to START and drives tx=0. With an idle, empty FIFO,
//    tx falls one cycle after the edge that sampled wr_en.
//  - START: holds tx=0 for one bit time, then goes to DATA with bit index 0.
//  - DATA: sends shift[0] first (LSB first). Shifts right after each bit time.
//    After bit 7 it goes to STOP.
//  - STOP: holds tx=1 for one bit time. At the end of that bit time:
//      - FIFO non-empty: pop and go straight to START (no idle gap).
//      - FIFO empty: go to IDLE.
//  - Frame length: exactly 10*CLKS_PER_BIT cycles.
//  - Reset mid-frame: at the reset edge tx=1 and state=IDLE. The frame in
//    progress is abandoned and the buffered bytes are discarded.
//  - No output is a function of wr_en in the same cycle; there is no
//    combinational path from input to output.
// TESTING  (CLKS_PER_BIT=4, FIFO_DEPTH=4, 20 ns clk)
//  1. Assert reset 2 cycles -> tx=1, busy=0, empty=1, full=0, overflow=0.
//  2. Write 0x00000088 once -> tx=0 for 4 cycles, then bits 0,0,0,1,0,0,0,1
//     (4 cycles each), then stop=1 for 4 cycles; busy=1 for 40 cycles.
//  3. Write 0xA5 then 0x3C on consecutive cycles -> two frames back to back,
//     no gap. Serial bits are 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0;
//     busy=1 for 80 cycles.
//  4. Idle, write bytes 1..6 on 6 consecutive cycles -> byte 1 popped at once,
//     bytes 2..5 buffered with full=1 after the 5th write, byte 6 dropped,
//     overflow=1. Exactly 5 frames sent, and overflow stays 1 afterwards.
//  5. Write 0xFFFFFF41 -> frame carries 0x41; upper 24 bits ignored.
//  6. Queue 3 bytes, assert reset at cycle 15 of frame 1 -> tx=1 at the next
//     edge, empty=1, overflow=0, and no further frames.

Source files
------------

// File: rtl/outport_uart_tx.sv
// -----------------------------------------------------------------------------
// outport_uart_tx
//
// Serial transmitter behind the MiniSRC output port. Each out-port write
// (wr_en pulse) pushes wr_data[7:0] into a small FIFO. A UART engine pops
// bytes from it and sends them as 8N1 frames on tx: a start bit, eight data
// bits LSB first, and one stop bit. Each bit lasts CLKS_PER_BIT cycles. When
// the FIFO still holds data at the end of a stop bit, the next frame starts
// at once, with no idle gap between frames.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per serial bit (>= 2)
//   FIFO_DEPTH    byte entries in the FIFO (power of two, >= 2)
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   synchronous reset, active-high
//   wr_en     in   one-cycle write strobe
//   wr_data   in   out-port bus value; only [7:0] is transmitted
//   tx        out  serial line, idles high (registered)
//   busy      out  frame in progress (decoded from FSM state register)
//   full      out  FIFO holds FIFO_DEPTH bytes (decoded from count register)
//   empty     out  FIFO holds no bytes (decoded from count register)
//   overflow  out  sticky: a write hit a full FIFO and was dropped
// -----------------------------------------------------------------------------
module outport_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    output logic        tx,
    output logic        busy,
    output logic        full,
    output logic        empty,
    output logic        overflow
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    // FIFO storage and bookkeeping
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    // Transmit engine
    state_e            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;

    logic full_s;
    logic empty_s;
    logic push_s;
    logic pop_s;
    logic baud_end_s;
    logic unused_upper_s;

    // The upper bus bits have no destination on the serial line.
    assign unused_upper_s = ^wr_data[31:8];

    assign full_s     = (count_q == CNT_FULL);
    assign empty_s    = (count_q == {CNT_W{1'b0}});
    // full is taken from the registered count, so a pop in the same cycle
    // cannot make room for a write that arrives while the FIFO is full.
    assign push_s     = wr_en & ~full_s;
    assign baud_end_s = (baud_q == BAUD_LAST);

    // FIFO pointer, count and overflow next-state
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (wr_en & full_s);

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO registers and byte storage
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            overflow_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (push_s) begin
                mem_q[wr_ptr_q] <= wr_data[7:0];
            end
        end
    end

    // Transmit FSM next-state, pop request and next tx level
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop_s   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                baud_d = {BAUD_W{1'b0}};
                bit_d  = 3'd0;
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    state_d = ST_START;
                    tx_d    = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                end
            end

            ST_START: begin
                if (baud_end_s) begin
                    baud_d  = {BAUD_W{1'b0}};
                    bit_d   = 3'd0;
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d  = baud_q + BAUD_W'(1);
                end
            end

            ST_DATA: begin
                if (baud_end_s) begin
                    baud_d  = {BAUD_W{1'b0}};
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        // shift_q[1] becomes shift[0] after this edge's shift
                        tx_d  = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            ST_STOP: begin
                if (baud_end_s) begin
                    baud_d = {BAUD_W{1'b0}};
                    if (!empty_s) begin
                        // Chain straight into the next frame, no idle bit
                        pop_s   = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = ST_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                baud_d  = {BAUD_W{1'b0}};
                bit_d   = 3'd0;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Transmit FSM state, counters, shift register and tx line
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            baud_q  <= {BAUD_W{1'b0}};
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = (state_q != ST_IDLE);
    assign full     = full_s;
    assign empty    = empty_s;
    assign overflow = overflow_q;

endmodule
